// File: rtl/line_fill_responder_pkg.sv
// Shared constants and state encoding for the i-cache line refill path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package line_fill_responder_pkg;

    // Reset levels for the active-low asynchronous reset.
    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_DISABLE = 1'b1;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Line geometry, shared with the i-cache so both sides agree on the layout.
    localparam int LFR_ADDR_WIDTH   = 32;
    localparam int LFR_SELECT_WIDTH = 4;
    localparam int LFR_RAM_WIDTH    = 32;
    localparam int LFR_LINE_WIDTH   = 8 * (1 << LFR_SELECT_WIDTH);
    localparam int LFR_BEATS        = LFR_LINE_WIDTH / LFR_RAM_WIDTH;

    // Refill controller states.
    typedef enum logic [2:0] {
        FILL_IDLE  = 3'd0,
        FILL_READ  = 3'd1,
        FILL_DRAIN = 3'd2,
        FILL_DONE  = 3'd3,
        FILL_COOL  = 3'd4
    } fill_state_e;

endpackage

// File: rtl/line_fill_responder.sv
// Purpose: fetches one cache line as BEATS word reads from a sync-read RAM and returns it.
// Latency: request sampled at edge e0 -> done pulse in cycle BEATS+2 (cycle 6 by default).
// Backpressure: none; cache holds mem_read_i until done, withdrawal/address change aborts.
module line_fill_responder
    import line_fill_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = LFR_ADDR_WIDTH,
    parameter int SELECT_WIDTH = LFR_SELECT_WIDTH,
    parameter int RAM_WIDTH    = LFR_RAM_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mem_read_i,
    input  logic [ADDR_WIDTH-1:0]                mem_addr_i,
    output logic [8*(1<<SELECT_WIDTH)-1:0]       mem_data_o,
    output logic                                 mem_done_o,
    output logic                                 ram_en_o,
    output logic [ADDR_WIDTH-1:0]                ram_addr_o,
    input  logic [RAM_WIDTH-1:0]                 ram_data_i,
    output logic                                 busy_o
);

    localparam int LINE_WIDTH = 8 * (1 << SELECT_WIDTH);
    localparam int BEATS      = LINE_WIDTH / RAM_WIDTH;
    localparam int BEAT_BYTES = RAM_WIDTH / 8;
    localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_W      = ADDR_WIDTH - SELECT_WIDTH;

    fill_state_e             state_q, state_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic [TAG_W-1:0]        base_q, base_d;
    logic [LINE_WIDTH-1:0]   buf_q, buf_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;

    logic                    abort;
    logic [IDX_W-1:0]        k_prev;
    logic [SELECT_WIDTH-1:0] beat_offset;
    logic                    unused_addr_bits;

    // Byte offsets within a line are implied by the beat counter.
    assign unused_addr_bits = ^mem_addr_i[SELECT_WIDTH-1:0];

    // A fill is abandoned when the cache drops the request or moves to another line.
    assign abort  = !mem_read_i || (mem_addr_i[ADDR_WIDTH-1:SELECT_WIDTH] != base_q);
    assign k_prev = k_q - 1'b1;

    // Offset stays inside the line, so the issued address can never leave it.
    assign beat_offset = SELECT_WIDTH'(k_q) * SELECT_WIDTH'(BEAT_BYTES);

    // Outputs decode only from registered state; no input reaches an output combinationally.
    assign ram_en_o   = (state_q == FILL_READ);
    assign ram_addr_o = (state_q == FILL_READ) ? {base_q, beat_offset} : '0;
    assign mem_done_o = (state_q == FILL_DONE);
    assign busy_o     = (state_q != FILL_IDLE);
    assign mem_data_o = line_q;

    // Next-state, beat counter and line assembly.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        buf_d   = buf_q;
        line_d  = line_q;
        case (state_q)
            FILL_IDLE: begin
                if (mem_read_i) begin
                    base_d  = mem_addr_i[ADDR_WIDTH-1:SELECT_WIDTH];
                    k_d     = '0;
                    state_d = FILL_READ;
                end
            end
            FILL_READ: begin
                // Data arriving now belongs to the beat issued last cycle.
                if (k_q != '0) begin
                    buf_d[RAM_WIDTH*int'(k_prev) +: RAM_WIDTH] = ram_data_i;
                end
                if (abort) begin
                    k_d     = '0;
                    state_d = FILL_IDLE;
                end else if (k_q == IDX_W'(BEATS - 1)) begin
                    k_d     = '0;
                    state_d = FILL_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            FILL_DRAIN: begin
                if (abort) begin
                    state_d = FILL_IDLE;
                end else begin
                    // Publish the whole line at once so old and new beats never mix.
                    line_d = buf_q;
                    line_d[LINE_WIDTH-1 -: RAM_WIDTH] = ram_data_i;
                    state_d = FILL_DONE;
                end
            end
            FILL_DONE: begin
                state_d = FILL_COOL;
            end
            FILL_COOL: begin
                // Gives the cache a cycle to drop its request before we listen again.
                state_d = FILL_IDLE;
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

    // State, counter, latched base and line registers; reset aborts any fill in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= FILL_IDLE;
            k_q     <= '0;
            base_q  <= '0;
            buf_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: directed scenarios plus randomized fills/aborts.
// Expected lines go to a scoreboard queue; a negedge monitor checks every done and RAM access.
// Stalls are bounded; an expired bound counts as a failure.
module tb_line_fill_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_read_i = 1'b0;
    logic [31:0]  mem_addr_i = '0;
    logic [127:0] mem_data_o;
    logic         mem_done_o;
    logic         ram_en_o;
    logic [31:0]  ram_addr_o;
    logic [31:0]  ram_data_i = '0;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;

    logic [127:0] sb[$];
    logic [31:0]  acc_line  = '0;
    logic [127:0] last_line = '0;
    bit           prev_en   = 1'b0;
    int           idx       = 0;
    logic [31:0]  run_base  = '0;

    line_fill_responder dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read_i (mem_read_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_o (mem_data_o),
        .mem_done_o (mem_done_o),
        .ram_en_o   (ram_en_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_i (ram_data_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return {a[31:4], 4'h0};
    endfunction

    // Reference line: four consecutive words from the line base, beat k in bits [32k +: 32].
    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = ram_word(line_base(a) + 32'(4 * k));
        end
        return l;
    endfunction

    // Synchronous-read RAM model.
    always @(posedge clk) begin
        if (ram_en_o) ram_data_i <= ram_word(ram_addr_o);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reset values, done pulses against the scoreboard, line hold, RAM address stream.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_data", mem_data_o, 0);
            chk("rst_done", mem_done_o, 0);
            chk("rst_ram_en", ram_en_o, 0);
            chk("rst_ram_addr", ram_addr_o, 0);
            chk("rst_busy", busy_o, 0);
            last_line = '0;
            prev_en   = 1'b0;
        end else begin
            if (mem_done_o) begin
                chk("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    last_line = sb.pop_front();
                    chk("done_line", mem_data_o, last_line);
                end
            end else begin
                chk("line_hold", mem_data_o, last_line);
            end
            if (ram_en_o) begin
                idx = prev_en ? idx + 1 : 0;
                if (idx == 0) run_base = acc_line;
                chk("ram_addr", ram_addr_o, run_base + 32'(4 * idx));
                chk("beats_per_run", idx < 4, 1);
            end
            prev_en = ram_en_o;
        end
    end

    // Waits for a done pulse; lat counts negedges from the current cycle (inclusive).
    task automatic wait_done(input int lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (mem_done_o) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        if (seen) chk("done_latency", n, lat);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [31:0] a);
        mem_read_i = 1'b1;
        mem_addr_i = a;
        acc_line   = line_base(a);
    endtask

    task automatic full_fill(input logic [31:0] a);
        start_req(a);
        sb.push_back(line_of(a));
        wait_done(7);
        next_cycle();
        mem_read_i = 1'b0;
        next_cycle();
    endtask

    // Drop the request in cycle c of the fill (1..5); no done may follow.
    task automatic withdraw(input logic [31:0] a, input int c);
        start_req(a);
        for (int i = 0; i < c; i++) next_cycle();
        mem_read_i = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("withdraw_busy", busy_o, 0);
        chk("withdraw_ram_en", ram_en_o, 0);
        next_cycle();
    endtask

    // Move to another line in cycle c (2..5): abort, re-accept, deliver only the new line.
    task automatic addr_change(input logic [31:0] a, input logic [31:0] na, input int c);
        start_req(a);
        for (int i = 0; i < c; i++) next_cycle();
        mem_addr_i = na;
        acc_line   = line_base(na);
        sb.push_back(line_of(na));
        wait_done(8);
        next_cycle();
        mem_read_i = 1'b0;
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] na;
        int          mode;

        // Reset held with a pending request: monitor checks all-zero outputs.
        start_req(32'h0000_1234);
        repeat (3) @(negedge clk);
        next_cycle();
        rst = 1'b1;
        sb.push_back(line_of(32'h0000_1234));
        wait_done(7);

        // Back-to-back: request held through done, new address during COOL.
        next_cycle();
        mem_addr_i = 32'h0000_2000;
        acc_line   = 32'h0000_2000;
        sb.push_back(line_of(32'h0000_2000));
        wait_done(8);
        next_cycle();
        mem_read_i = 1'b0;
        next_cycle();

        withdraw(32'h0000_1230, 2);
        addr_change(32'h0000_1230, 32'h0000_4570, 2);
        full_fill(32'hFFFF_FFF4);

        // Randomized mix of complete fills, withdrawals and address changes.
        for (int it = 0; it < 40; it++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31:8] = 24'hFF_FFFF;
            mode = $urandom_range(0, 2);
            case (mode)
                0: full_fill(a);
                1: withdraw(a, $urandom_range(1, 5));
                default: begin
                    na = a + ($urandom_range(1, 4000) << 4);
                    addr_change(a, na, $urandom_range(2, 5));
                end
            endcase
        end

        // Reset in the middle of a fill: immediate abort, line cleared, no done.
        start_req(32'h0000_8888);
        repeat (3) next_cycle();
        rst        = 1'b0;
        mem_read_i = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_done", mem_done_o, 0);
        chk("midrst_line", mem_data_o, 0);
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
        full_fill(32'h0000_ABC8);
        repeat (3) next_cycle();

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
- Memory-side responder for the instruction-cache refill interface.
- Accepts a line read request (read strobe plus address), fetches one cache line as BEATS sequential word reads from a synchronous-read RAM, and assembles the beats into a BENCH_WIDTH line.
- Returns the line with a single-cycle done pulse.
- Sits between the i-cache and the RAM or memory arbiter.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- SELECT_WIDTH, 4, log2 of line size in bytes; line base = {addr[ADDR_WIDTH-1:SELECT_WIDTH], SELECT_WIDTH'b0}.
- RAM_WIDTH, 32, RAM data width per beat.
- BENCH_WIDTH, 8*(1<<SELECT_WIDTH) = 128, line width.
- BEATS, BENCH_WIDTH/RAM_WIDTH = 4, reads per line.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- mem_read_i  in  1  line request from cache; held high until done.
- mem_addr_i  in  ADDR_WIDTH  requested address; low SELECT_WIDTH bits ignored.
- mem_data_o  out  BENCH_WIDTH  assembled line; beat k occupies [RAM_WIDTH*k +: RAM_WIDTH].
- mem_done_o  out  1  one-cycle pulse; mem_data_o valid in that cycle.
- ram_en_o  out  1  RAM read enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_data_i  in  RAM_WIDTH  RAM read data, valid the cycle after ram_en_o/ram_addr_o.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counters=0, latched base=0.
  - mem_data_o=0, mem_done_o=0, ram_en_o=0, ram_addr_o=0, busy_o=0.
  - Reset mid-fill aborts immediately; no done pulse is issued.
- States: IDLE, FILL, DRAIN, DONE, COOL.
- IDLE: if mem_read_i=1 at a clock edge, latch base, set issue counter k=0, go to FILL.
- FILL: ram_en_o=1, ram_addr_o = base + k*(RAM_WIDTH/8).
  - Each cycle: k increments, and the beat returned for k-1 (if k>0) is written into its slot of the line register.
  - After k=BEATS-1 has been issued, go to DRAIN.
- DRAIN: ram_en_o=0; capture beat BEATS-1; go to DONE.
- DONE: mem_done_o=1 for exactly this cycle; mem_data_o shows the complete new line; go to COOL.
- COOL: one cycle in which requests are ignored, giving the cache time to drop mem_read_i after its fill; then IDLE.
- Latency (default params): request sampled at edge e0; FILL in cycles 1-4; DRAIN in cycle 5; mem_done_o high in cycle 6; earliest next acceptance at the edge ending cycle 8.
- mem_data_o is a register. It holds the last completed line until the next DONE. Partial beats are assembled in a separate buffer, so mem_data_o never shows a mix of old and new beats.
- Abort in FILL or DRAIN goes to IDLE next cycle, with no done pulse and mem_data_o unchanged. Two triggers:
  - mem_read_i=0 (request withdrawn).
  - mem_addr_i line bits differ from the latched base (address changed).
  - A still-asserted request is re-accepted from IDLE on the following edge with the new address.
- ram_en_o, ram_addr_o, mem_done_o and busy_o decode from registered state and counters only; there is no combinational path from mem_*_i to any output.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. A line at base 0xFFFF_FFF0 issues F0, F4, F8, FC and never crosses its line.

Decomposition:
- Shared defines file:
  - `RstEnable 1'b0 and `RstDisable 1'b1.
  - `ZeroWord.
  - state encodings `FillIdle, `FillRead, `FillDrain, `FillDone, `FillCool (3 bits).
  - line/beat widths, so the i-cache uses the same constants.
- Single module. The line assembly buffer is a few lines and gets no sub-module.

Test Plan:
- Reset: hold rst=0 with mem_read_i=1 -> all outputs 0, no ram_en_o. Release rst -> FILL begins on the next edge.
- Basic fill: RAM word at byte address A = A^32'hA5A5_0000; request 0x0000_1234 -> ram_addr_o 0x1230, 0x1234, 0x1238, 0x123C in consecutive cycles; mem_done_o high in cycle 6 only; mem_data_o = {A5A5_123C, A5A5_1238, A5A5_1234, A5A5_1230}.
- Back-to-back: keep mem_read_i high through DONE, then change the address to 0x2000 -> COOL ignores the request; new fill for 0x2000 accepted at edge 8; line 0x1230 stays on mem_data_o until the second done.
- Withdrawal: drop mem_read_i in FILL cycle 2 -> no done pulse, ram_en_o=0 next cycle, mem_data_o unchanged, busy_o=0 after one cycle.
- Address change: switch mem_addr_i from 0x1230 to 0x4570 mid-FILL -> abort, re-accept, then a done pulse with line 0x4570 contents only.
- Wrap: request 0xFFFF_FFF4 -> addresses F0, F4, F8, FC; done with 4 correct beats; no access at 0x0000_0000.
